ex_mem_pipe_reg: RTL and testbench
==================================

Name: ex_mem_pipe_reg

Overview:
Parametrised EX/MEM pipeline register, the successor to the plain EX/MEM latch. It adds synchronous reset, a valid/ready handshake, a 2-entry skid buffer for full-throughput back-pressure, and a flush that inserts bubbles. It sits between the ALU/branch-adder stage and the data-memory stage. It carries the WB/M control, the branch target, the ALU result, the ALU zero flag, store data, and the destination register.

Parameters:
DATA_W, 32, width of adder, ALU result and store-data fields
REG_W, 5, width of destination register index
WB_W, 2, width of write-back control field
M_W, 2, width of memory-stage control field

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
flush  in  1  discard all held entries (branch taken / exception)
in_valid  in  1  EX stage presents a valid instruction
in_ready  out  1  register can accept this cycle
ctlwb_in  in  WB_W  write-back control
ctlm_in  in  M_W  memory control
adder_in  in  DATA_W  branch target
alu_result_in  in  DATA_W  ALU result
zero_in  in  1  ALU zero flag
rdata2_in  in  DATA_W  store data
muxout_in  in  REG_W  destination register
out_valid  out  1  MEM stage sees a valid instruction
out_ready  in  1  MEM stage accepts this cycle
ctlwb_out  out  WB_W  held write-back control; 0 when out_valid=0
ctlm_out  out  M_W  held memory control; 0 when out_valid=0
adder_out, alu_result_out, rdata2_out  out  DATA_W  held data fields
alu_zero  out  1  held zero flag
muxout_out  out  REG_W  held destination register
occupancy  out  2  entries held (0..2)

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high. All state changes occur on the rising edge of `clk`.
- Storage: main entry M drives the outputs; skid entry S catches an input accepted while M is stalled.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = (occupancy != 2). It is derived from registered state only; no combinational path from out_ready.
- out_valid = M valid.
- States: EMPTY (occ 0), ONE (M valid), FULL (M and S valid).
- EMPTY: in_fire -> ONE, M <= inputs.
- ONE:
  - in_fire & out_fire -> ONE, M <= inputs.
  - out_fire only -> EMPTY.
  - in_fire only -> FULL, S <= inputs.
  - neither -> hold.
- FULL: in_ready=0.
  - out_fire -> ONE, M <= S.
  - else hold.
- Ordering: strict FIFO; S is never bypassed.
- Latency and throughput: 1 cycle from in_fire to out_valid when EMPTY. Sustains 1 transfer/cycle while out_ready=1.
- Bubble squashing: when out_valid=0, ctlwb_out and ctlm_out read 0, so MEM/WB never writes on a bubble. Data outputs retain their last loaded value.
- Flush: next cycle -> EMPTY and occupancy=0.
  - Any in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle still completes.
  - Flush has priority over every transition.
- Reset: has priority over flush. Next cycle:
  - occupancy=0, out_valid=0, in_ready=1.
  - All data/control outputs and internal entries = 0.
  - Reset mid-transfer drops both entries.
- Widths: fields are copied verbatim, with no extension or truncation. Parameters must be >= 1.
- Holding: with no transition, every output is bit-stable across cycles.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> occupancy=0, out_valid=0, in_ready=1, all outputs 0. Outputs stay 0 with in_valid=0.
- Streaming: out_ready=1, 4 back-to-back inputs alu_result_in=0x11,0x22,0x33,0x44 -> same values on alu_result_out on cycles 1..4 after each in_fire. occupancy never exceeds 1.
- Back-pressure: out_ready=0, send A (adder_in=0x100) then B (0x200) -> occupancy=2, in_ready=0. A third input C is not accepted. Raise out_ready -> outputs A, B, C in order, no loss or duplication.
- Bubble squash: send one entry with ctlwb_in=2'b11, ctlm_in=2'b10, then hold in_valid=0 with out_ready=1 -> next cycle out_valid=0, ctlwb_out=0, ctlm_out=0. rdata2_out keeps the last value.
- Flush while FULL with in_valid=1: flush=1 one cycle -> occupancy=0, out_valid=0, and the input from that cycle never appears. A later input emerges with 1-cycle latency.
- Reset vs flush and parameters: rst=1 and flush=1 together while FULL -> all outputs 0 next cycle. Rerun the streaming test with DATA_W=64, REG_W=6, M_W=3 -> identical behaviour.

Source files
------------

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// Entry M drives the MEM stage. Entry S catches an instruction accepted while M is stalled.
module ex_mem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int WB_W   = 2,
  parameter int M_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   ctlwb_in,
  input  logic [M_W-1:0]    ctlm_in,
  input  logic [DATA_W-1:0] adder_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic              zero_in,
  input  logic [DATA_W-1:0] rdata2_in,
  input  logic [REG_W-1:0]  muxout_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   ctlwb_out,
  output logic [M_W-1:0]    ctlm_out,
  output logic [DATA_W-1:0] adder_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic              alu_zero,
  output logic [DATA_W-1:0] rdata2_out,
  output logic [REG_W-1:0]  muxout_out,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [WB_W-1:0]   ctlwb;
    logic [M_W-1:0]    ctlm;
    logic [DATA_W-1:0] adder;
    logic [DATA_W-1:0] alu_result;
    logic              zero;
    logic [DATA_W-1:0] rdata2;
    logic [REG_W-1:0]  muxout;
  } entry_t;

  // The encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;
  entry_t m_q, m_d;
  entry_t s_q, s_d;
  entry_t in_entry;
  logic   in_fire;
  logic   out_fire;

  assign in_entry = '{
    ctlwb:      ctlwb_in,
    ctlm:       ctlm_in,
    adder:      adder_in,
    alu_result: alu_result_in,
    zero:       zero_in,
    rdata2:     rdata2_in,
    muxout:     muxout_in
  };

  // Both handshake outputs depend only on registered state, never on out_ready.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign occupancy = state_q;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      // Entry contents are kept so the data outputs still show the last loaded value.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            m_d     = in_entry;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            m_d = in_entry;
          end else if (out_fire) begin
            state_d = EMPTY;
          end else if (in_fire) begin
            state_d = FULL;
            s_d     = in_entry;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = ONE;
            m_d     = s_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the entries are reset as well, because the data outputs must read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  // Control is squashed on a bubble so MEM/WB never writes; data fields simply hold.
  assign ctlwb_out      = out_valid ? m_q.ctlwb : '0;
  assign ctlm_out       = out_valid ? m_q.ctlm  : '0;
  assign adder_out      = m_q.adder;
  assign alu_result_out = m_q.alu_result;
  assign alu_zero       = m_q.zero;
  assign rdata2_out     = m_q.rdata2;
  assign muxout_out     = m_q.muxout;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed testbench for ex_mem_pipe_reg: default-width instance plus a wide instance
// (DATA_W=64, REG_W=6, M_W=3) that reruns the streaming scenario.
module tb_ex_mem_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Default-width instance
  logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, zero_in = 1'b0;
  logic [1:0]  ctlwb_in = '0, ctlm_in = '0;
  logic [31:0] adder_in = '0, alu_result_in = '0, rdata2_in = '0;
  logic [4:0]  muxout_in = '0;
  logic        in_ready, out_valid, alu_zero;
  logic [1:0]  ctlwb_out, ctlm_out, occupancy;
  logic [31:0] adder_out, alu_result_out, rdata2_out;
  logic [4:0]  muxout_out;

  ex_mem_pipe_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in), .adder_in(adder_in),
    .alu_result_in(alu_result_in), .zero_in(zero_in), .rdata2_in(rdata2_in),
    .muxout_in(muxout_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .ctlwb_out(ctlwb_out), .ctlm_out(ctlm_out), .adder_out(adder_out),
    .alu_result_out(alu_result_out), .alu_zero(alu_zero), .rdata2_out(rdata2_out),
    .muxout_out(muxout_out), .occupancy(occupancy)
  );

  // Wide instance
  logic        w_flush = 1'b0, w_in_valid = 1'b0, w_out_ready = 1'b0, w_zero_in = 1'b0;
  logic [1:0]  w_ctlwb_in = '0;
  logic [2:0]  w_ctlm_in = '0;
  logic [63:0] w_adder_in = '0, w_alu_result_in = '0, w_rdata2_in = '0;
  logic [5:0]  w_muxout_in = '0;
  logic        w_in_ready, w_out_valid, w_alu_zero;
  logic [1:0]  w_ctlwb_out, w_occupancy;
  logic [2:0]  w_ctlm_out;
  logic [63:0] w_adder_out, w_alu_result_out, w_rdata2_out;
  logic [5:0]  w_muxout_out;

  ex_mem_pipe_reg #(.DATA_W(64), .REG_W(6), .WB_W(2), .M_W(3)) dut_wide (
    .clk(clk), .rst(rst), .flush(w_flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .ctlwb_in(w_ctlwb_in), .ctlm_in(w_ctlm_in), .adder_in(w_adder_in),
    .alu_result_in(w_alu_result_in), .zero_in(w_zero_in), .rdata2_in(w_rdata2_in),
    .muxout_in(w_muxout_in),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .ctlwb_out(w_ctlwb_out), .ctlm_out(w_ctlm_out), .adder_out(w_adder_out),
    .alu_result_out(w_alu_result_out), .alu_zero(w_alu_zero), .rdata2_out(w_rdata2_out),
    .muxout_out(w_muxout_out), .occupancy(w_occupancy)
  );

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] wb, input logic [1:0] m,
                       input logic [31:0] adder, input logic [31:0] alu, input logic z,
                       input logic [31:0] rd2, input logic [4:0] rd);
    in_valid      = v;
    ctlwb_in      = wb;
    ctlm_in       = m;
    adder_in      = adder;
    alu_result_in = alu;
    zero_in       = z;
    rdata2_in     = rd2;
    muxout_in     = rd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (occupancy !== 2'd0) $display("FAIL reset_occ got=%0d exp=0", occupancy); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passes++;
    checks++;
    if ({ctlwb_out, ctlm_out, adder_out, alu_result_out, alu_zero, rdata2_out, muxout_out} !== '0)
      $display("FAIL reset_outputs got=%h/%h/%h/%h/%b/%h/%h exp=all zero", ctlwb_out, ctlm_out,
               adder_out, alu_result_out, alu_zero, rdata2_out, muxout_out);
    else passes++;
    checks++; if (w_occupancy !== 2'd0 || w_alu_result_out !== 64'd0)
      $display("FAIL reset_wide got occ=%0d alu=%h exp occ=0 alu=0", w_occupancy, w_alu_result_out);
    else passes++;
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({out_valid, ctlwb_out, ctlm_out, adder_out, alu_result_out, rdata2_out, muxout_out} !== '0)
      $display("FAIL reset_idle got valid=%b alu=%h exp all zero", out_valid, alu_result_out);
    else passes++;
  endtask

  task automatic test_streaming();
    logic [31:0] vals [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b01, 2'b00, 32'h0, vals[i], 1'b0, 32'h0, 5'(i + 1));
      tick();
      checks++; if (alu_result_out !== vals[i] || out_valid !== 1'b1)
        $display("FAIL stream_alu%0d got=%h valid=%b exp=%h valid=1", i, alu_result_out, out_valid, vals[i]);
      else passes++;
      checks++; if (occupancy !== 2'd1)
        $display("FAIL stream_occ%0d got=%0d exp=1", i, occupancy);
      else passes++;
    end
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 5'h0);
    tick();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
      $display("FAIL stream_drain got valid=%b occ=%0d exp valid=0 occ=0", out_valid, occupancy);
    else passes++;
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 2'b00, 32'h100, 32'h0, 1'b0, 32'h0, 5'h0);
    tick();
    checks++; if (occupancy !== 2'd1 || adder_out !== 32'h100)
      $display("FAIL bp_a got occ=%0d adder=%h exp occ=1 adder=100", occupancy, adder_out);
    else passes++;
    drive(1'b1, 2'b00, 2'b00, 32'h200, 32'h0, 1'b0, 32'h0, 5'h0);
    tick();
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0)
      $display("FAIL bp_full got occ=%0d in_ready=%b exp occ=2 in_ready=0", occupancy, in_ready);
    else passes++;
    drive(1'b1, 2'b00, 2'b00, 32'h300, 32'h0, 1'b0, 32'h0, 5'h0);
    tick();
    checks++; if (occupancy !== 2'd2 || adder_out !== 32'h100)
      $display("FAIL bp_c_blocked got occ=%0d adder=%h exp occ=2 adder=100", occupancy, adder_out);
    else passes++;
    out_ready = 1'b1;
    tick();
    checks++; if (adder_out !== 32'h200 || occupancy !== 2'd1)
      $display("FAIL bp_b got adder=%h occ=%0d exp adder=200 occ=1", adder_out, occupancy);
    else passes++;
    tick();
    checks++; if (adder_out !== 32'h300 || occupancy !== 2'd1)
      $display("FAIL bp_c got adder=%h occ=%0d exp adder=300 occ=1", adder_out, occupancy);
    else passes++;
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 5'h0);
    tick();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
      $display("FAIL bp_drain got valid=%b occ=%0d exp valid=0 occ=0", out_valid, occupancy);
    else passes++;
  endtask

  task automatic test_bubble_squash();
    out_ready = 1'b1;
    drive(1'b1, 2'b11, 2'b10, 32'h0, 32'h0, 1'b1, 32'hDEAD, 5'h7);
    tick();
    checks++; if (out_valid !== 1'b1 || ctlwb_out !== 2'b11 || ctlm_out !== 2'b10 || alu_zero !== 1'b1)
      $display("FAIL bubble_load got valid=%b wb=%b m=%b z=%b exp 1/11/10/1", out_valid, ctlwb_out, ctlm_out, alu_zero);
    else passes++;
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 5'h0);
    tick();
    checks++; if (out_valid !== 1'b0 || ctlwb_out !== 2'b00 || ctlm_out !== 2'b00)
      $display("FAIL bubble_ctl got valid=%b wb=%b m=%b exp 0/00/00", out_valid, ctlwb_out, ctlm_out);
    else passes++;
    checks++; if (rdata2_out !== 32'hDEAD || muxout_out !== 5'h7)
      $display("FAIL bubble_hold got rdata2=%h rd=%h exp rdata2=dead rd=07", rdata2_out, muxout_out);
    else passes++;
    tick();
    checks++; if (rdata2_out !== 32'hDEAD || ctlwb_out !== 2'b00)
      $display("FAIL bubble_stable got rdata2=%h wb=%b exp dead/00", rdata2_out, ctlwb_out);
    else passes++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 2'b01, 32'h1, 32'h0, 1'b0, 32'h0, 5'h0);
    tick();
    drive(1'b1, 2'b01, 2'b01, 32'h2, 32'h0, 1'b0, 32'h0, 5'h0);
    tick();
    checks++; if (occupancy !== 2'd2)
      $display("FAIL flush_fill got occ=%0d exp=2", occupancy);
    else passes++;
    flush = 1'b1;
    drive(1'b1, 2'b01, 2'b01, 32'hBAD, 32'h0, 1'b0, 32'h0, 5'h0);
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 5'h0);
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || ctlwb_out !== 2'b00)
      $display("FAIL flush_full got occ=%0d valid=%b in_ready=%b wb=%b exp 0/0/1/00", occupancy, out_valid, in_ready, ctlwb_out);
    else passes++;
    // Flush while ONE, when the flush-cycle input really fires.
    drive(1'b1, 2'b01, 2'b01, 32'h3, 32'h0, 1'b0, 32'h0, 5'h0);
    tick();
    flush = 1'b1;
    drive(1'b1, 2'b01, 2'b01, 32'hBAD, 32'h0, 1'b0, 32'h0, 5'h0);
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 5'h0);
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0)
      $display("FAIL flush_one got occ=%0d valid=%b exp occ=0 valid=0", occupancy, out_valid);
    else passes++;
    tick();
    checks++; if (out_valid !== 1'b0 || adder_out === 32'hBAD)
      $display("FAIL flush_discard got valid=%b adder=%h exp valid=0 adder!=bad", out_valid, adder_out);
    else passes++;
    out_ready = 1'b1;
    drive(1'b1, 2'b10, 2'b01, 32'h55, 32'h0, 1'b0, 32'h0, 5'h0);
    tick();
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 5'h0);
    checks++; if (out_valid !== 1'b1 || adder_out !== 32'h55 || ctlwb_out !== 2'b10)
      $display("FAIL flush_after got valid=%b adder=%h wb=%b exp 1/55/10", out_valid, adder_out, ctlwb_out);
    else passes++;
    tick();
  endtask

  task automatic test_reset_vs_flush();
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 2'b11, 32'hA, 32'hB, 1'b1, 32'hC, 5'h1F);
    tick();
    drive(1'b1, 2'b11, 2'b11, 32'hD, 32'hE, 1'b1, 32'hF, 5'h1E);
    tick();
    checks++; if (occupancy !== 2'd2)
      $display("FAIL rstflush_fill got occ=%0d exp=2", occupancy);
    else passes++;
    rst = 1'b1;
    flush = 1'b1;
    tick();
    rst = 1'b0;
    flush = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 5'h0);
    checks++;
    if ({occupancy, out_valid, ctlwb_out, ctlm_out, adder_out, alu_result_out, alu_zero, rdata2_out, muxout_out} !== '0
        || in_ready !== 1'b1)
      $display("FAIL rstflush_zero got occ=%0d valid=%b adder=%h alu=%h rd2=%h rd=%h exp all zero",
               occupancy, out_valid, adder_out, alu_result_out, rdata2_out, muxout_out);
    else passes++;
    // The skid entry must be cleared too: releasing back-pressure produces nothing.
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || adder_out !== 32'h0)
      $display("FAIL rstflush_skid got valid=%b adder=%h exp valid=0 adder=0", out_valid, adder_out);
    else passes++;
  endtask

  task automatic test_wide_streaming();
    logic [63:0] vals [4] = '{64'h1111_0000_0000_0011, 64'h2222_0000_0000_0022,
                              64'h3333_0000_0000_0033, 64'hFFFF_0000_0000_0044};
    logic [5:0]  rds  [4] = '{6'h3F, 6'h20, 6'h01, 6'h2A};
    w_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_in_valid      = 1'b1;
      w_alu_result_in = vals[i];
      w_muxout_in     = rds[i];
      w_ctlm_in       = 3'b101;
      w_ctlwb_in      = 2'b10;
      tick();
      checks++;
      if (w_alu_result_out !== vals[i] || w_muxout_out !== rds[i] || w_ctlm_out !== 3'b101 || w_occupancy !== 2'd1)
        $display("FAIL wide_stream%0d got alu=%h rd=%h m=%b occ=%0d exp alu=%h rd=%h m=101 occ=1",
                 i, w_alu_result_out, w_muxout_out, w_ctlm_out, w_occupancy, vals[i], rds[i]);
      else passes++;
    end
    w_in_valid = 1'b0;
    tick();
    checks++; if (w_out_valid !== 1'b0 || w_ctlm_out !== 3'b000 || w_alu_result_out !== vals[3])
      $display("FAIL wide_drain got valid=%b m=%b alu=%h exp 0/000/%h", w_out_valid, w_ctlm_out, w_alu_result_out, vals[3]);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_bubble_squash();
    test_flush();
    test_reset_vs_flush();
    test_wide_streaming();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
